x_muldiv_seq: RTL
=================

# x_muldiv_seq

Execute-stage multicycle sequencer that replaces the combinational mul/div `continue` gating in the X stage. It:
- decodes R-type mul/div (opcode 00000, ALU op 00110 / 00111);
- launches the shared iterative multiply/divide unit and stalls the pipeline while that unit runs;
- captures the result in a hold register and presents it for exactly one cycle;
- raises the rstatus exception code on unit overflow or divide-by-zero.

It sits between the X-stage control decode and the F/D/X pipeline latches' enable logic.

## Interface
Parameters:
- DATA_W, 32, operand/result/error-code width
- TIMEOUT, 64, BUSY cycles allowed before watchdog abort (used only with MD_TIMEOUT_EN)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  X stage holds a live instruction
- flush  in  1  kill the X-stage instruction (taken branch/jump)
- opcode  in  5  instruction opcode
- alu_op  in  5  instruction ALU op field
- data_a, data_b  in  DATA_W  operands
- md_start  out  1  one-cycle launch pulse to the mul/div unit
- md_div  out  1  operation select, held from launch: 0 = mul, 1 = div
- md_a, md_b  out  DATA_W  latched operands, held from launch
- md_abort  out  1  one-cycle pulse that cancels the unit
- md_ready  in  1  unit result valid (single-cycle pulse)
- md_res  in  DATA_W  unit result
- md_exc  in  1  unit overflow or divide-by-zero, qualified by md_ready
- stall  out  1  freeze PC and the F/D and D/X latches
- busy  out  1  state is not IDLE
- res_valid  out  1  result present this cycle
- res  out  DATA_W  captured result
- err_valid  out  1  rstatus write request
- err_code  out  DATA_W  rstatus value: 4 = mul, 5 = div, 6 = timeout; zero-extended

## Operation
Launch condition:
- launch = state IDLE & ex_valid & ~flush & (is_mul | is_div).
- Any other opcode/alu_op combination is ignored; the block never stalls for it.

States: IDLE, BUSY, DONE.

IDLE:
- On launch: pulse md_start and latch data_a, data_b and md_div into the md_a, md_b and md_div registers.
- Go to BUSY and clear the cycle counter.

BUSY:
- The counter increments each cycle and saturates at TIMEOUT.
- On md_ready & ~flush: capture md_res into res. If md_exc, res captures 0, err_valid will be raised and err_code is set to 4 (mul) or 5 (div). Go to DONE.
- On flush, at any time in BUSY: pulse md_abort and go to IDLE. This holds even when md_ready is asserted in the same cycle; flush wins and nothing is captured.
- Timeout (MD_TIMEOUT_EN only): when counter = TIMEOUT-1 with no md_ready, pulse md_abort and go to DONE with res = 0, err_code = 6, err_valid.

DONE:
- res_valid = 1 for one cycle; err_valid as set in BUSY. Go to IDLE.
- flush in DONE suppresses res_valid and err_valid.
- A new launch from DONE is not possible. The next mul/div launches at the earliest one cycle after DONE, from IDLE.

stall output:
- stall = launch | (state == BUSY).
- stall is combinational from inputs in IDLE and registered-state-driven in BUSY.
- stall is 0 in DONE, so the latches advance with res valid.

Widths: the counter is clog2(TIMEOUT+1) bits and never wraps.

## Timing
Reset values, asserted asynchronously:
- state = IDLE; counter = 0.
- stall, busy, md_start, md_abort, res_valid, err_valid = 0.
- md_div = 0; md_a, md_b, res, err_code = 0.

Cycle timing:
- Launch cycle T: md_start = 1 and stall = 1.
- busy = 1 from T+1.
- md_ready at cycle R gives res_valid at R+1, stall = 0 at R+1 and IDLE at R+2.
- Minimum occupancy: md_ready at T+1 gives DONE at T+2, i.e. 3 cycles.
- md_ready outside BUSY is ignored.
- Reset deasserted mid-operation: the block restarts cleanly in IDLE and drives no md_abort. The unit is reset by the same reset_n.

## Configuration
- MD_TIMEOUT_EN defined: the watchdog counter and error code 6 are built.
- MD_TIMEOUT_EN undefined: the counter logic is removed and BUSY waits indefinitely for md_ready or flush.
- The TIMEOUT parameter is unused when MD_TIMEOUT_EN is undefined.

## Test plan
- mul launch: data_a = 7, data_b = 6, md_ready 5 cycles after md_start with md_res = 42 -> stall high for exactly 6 cycles (T..T+5); res_valid with res = 42 at T+6; err_valid = 0.
- div by zero: div launch, md_ready with md_exc = 1 -> res = 0, err_valid = 1, err_code = 5 in the DONE cycle.
- flush coincident with md_ready in BUSY -> md_abort pulses, res_valid never asserts, back in IDLE the next cycle.
- Non-muldiv op (opcode 00101, addi) with ex_valid = 1 -> stall = 0 and md_start = 0 throughout.
- MD_TIMEOUT_EN, TIMEOUT = 8, md_ready never asserted -> md_abort on the 8th BUSY cycle; next cycle res_valid = 1, res = 0, err_code = 6.
- Back-to-back mul, div -> second md_start no earlier than one cycle after the first DONE; reset_n pulsed low mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/x_muldiv_seq_if.sv
// Handshake bundle between the X-stage mul/div sequencer (master) and the
// shared iterative multiply/divide unit (slave).
interface x_muldiv_seq_if #(
    parameter int DATA_W = 32
);
    logic              md_start;
    logic              md_div;
    logic [DATA_W-1:0] md_a;
    logic [DATA_W-1:0] md_b;
    logic              md_abort;
    logic              md_ready;
    logic [DATA_W-1:0] md_res;
    logic              md_exc;

    modport master (
        output md_start, md_div, md_a, md_b, md_abort,
        input  md_ready, md_res, md_exc
    );

    modport slave (
        input  md_start, md_div, md_a, md_b, md_abort,
        output md_ready, md_res, md_exc
    );
endinterface

// File: rtl/x_muldiv_seq.sv
// X-stage multicycle mul/div sequencer: launches the shared unit, stalls F/D/X
// while it runs, presents the result for one cycle. MD_TIMEOUT_EN adds a watchdog.
module x_muldiv_seq #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic                  flush,
    input  logic [4:0]            opcode,
    input  logic [4:0]            alu_op,
    input  logic [DATA_W-1:0]     data_a,
    input  logic [DATA_W-1:0]     data_b,
    x_muldiv_seq_if.master        md,
    output logic                  stall,
    output logic                  busy,
    output logic                  res_valid,
    output logic [DATA_W-1:0]     res,
    output logic                  err_valid,
    output logic [DATA_W-1:0]     err_code
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nx;
    logic              is_mul, is_div, launch;
    logic              cap, tmo, abort;
    logic              div_r, err_r;
    logic [DATA_W-1:0] a_r, b_r, res_r, err_code_r;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("x_muldiv_seq: TIMEOUT must be at least 1");
    end

    assign is_mul = (opcode == 5'b00000) && (alu_op == 5'b00110);
    assign is_div = (opcode == 5'b00000) && (alu_op == 5'b00111);
    // Gated by reset_n so no launch pulse leaks out while reset is held.
    assign launch = reset_n && (state == IDLE) && ex_valid && !flush && (is_mul || is_div);

`ifdef MD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         cnt <= '0;
        else if (launch)                      cnt <= '0;
        else if (state == BUSY && cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        tmo      = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: if (launch) state_nx = BUSY;
            BUSY: begin
                // flush beats a coincident md_ready: the instruction is dead.
                if (flush) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else if (md.md_ready) begin
                    cap      = 1'b1;
                    state_nx = DONE;
                end
`ifdef MD_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    abort    = 1'b1;
                    tmo      = 1'b1;
                    state_nx = DONE;
                end
`endif
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_r      <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            res_r      <= '0;
            err_r      <= 1'b0;
            err_code_r <= '0;
        end else begin
            if (launch) begin
                div_r <= is_div;
                a_r   <= data_a;
                b_r   <= data_b;
            end
            if (cap) begin
                res_r <= md.md_exc ? '0 : md.md_res;
                err_r <= md.md_exc;
                if (md.md_exc) err_code_r <= div_r ? DATA_W'(5) : DATA_W'(4);
            end else if (tmo) begin
                res_r      <= '0;
                err_r      <= 1'b1;
                err_code_r <= DATA_W'(6);
            end
        end
    end

    // Operands bypass the latch in the launch cycle so the unit sees them with md_start.
    assign md.md_start = launch;
    assign md.md_div   = launch ? is_div : div_r;
    assign md.md_a     = launch ? data_a : a_r;
    assign md.md_b     = launch ? data_b : b_r;
    assign md.md_abort = abort;

    assign stall     = launch || (state == BUSY);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE) && !flush;
    assign err_valid = (state == DONE) && !flush && err_r;
    assign res       = res_r;
    assign err_code  = err_code_r;
endmodule
